// File: rtl/sha_digest_collector_if.sv
// Digest collector bundle: AXI-Stream digest input plus host valid/ready output.
// master = stream source / host side, slave = collector side.
interface sha_digest_collector_if #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WORDS  = 32
);
    logic                              TVALID;
    logic                              TREADY;
    logic [DATA_WIDTH-1:0]             TDATA;
    logic                              TLAST;
    logic [3:0]                        TUSER;
    logic                              dig_valid;
    logic                              dig_ready;
    logic [MAX_WORDS*DATA_WIDTH-1:0]   digest;
    logic [5:0]                        dig_words;
    logic [1:0]                        dig_mode;
    logic                              dig_err;

    modport master (
        output TVALID, TDATA, TLAST, TUSER, dig_ready,
        input  TREADY, dig_valid, digest, dig_words, dig_mode, dig_err
    );

    modport slave (
        input  TVALID, TDATA, TLAST, TUSER, dig_ready,
        output TREADY, dig_valid, digest, dig_words, dig_mode, dig_err
    );
endinterface

// File: rtl/sha_digest_collector.sv
// Assembles one SHA-3 digest from a 16-bit stream and hands it to the host.
// Optional length checking: define SHA_DIGEST_LEN_CHECK_EN.
module sha_digest_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WORDS  = 32
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    sha_digest_collector_if.slave  bus
);
    localparam int IW = $clog2(MAX_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    state_t                                r_state;
    logic                                  r_tready;
    logic                                  r_valid;
    logic [MAX_WORDS-1:0][DATA_WIDTH-1:0]  r_words;
    logic [5:0]                            r_count;
    logic [1:0]                            r_mode;

    logic          w_accept;
    logic          w_hs;
    logic          w_full;
    logic [5:0]    w_cnt_nx;
    logic          w_go_done;
    logic [IW-1:0] w_idx;

    assign w_accept = bus.TVALID & r_tready;
    assign w_hs     = r_valid & bus.dig_ready;
    assign w_full   = (r_count == 6'(MAX_WORDS));
    assign w_idx    = r_count[IW-1:0];

    always_comb begin
        w_cnt_nx  = w_full ? r_count : r_count + 6'd1;
        w_go_done = 1'b0;
        if (w_accept) begin
            if (bus.TLAST)
                w_go_done = 1'b1;
`ifdef SHA_DIGEST_LEN_CHECK_EN
            // a full register without TLAST ends the capture early
            else if (r_state == S_COLLECT && w_cnt_nx == 6'(MAX_WORDS))
                w_go_done = 1'b1;
`endif
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state  <= S_IDLE;
            r_tready <= 1'b1;
            r_valid  <= 1'b0;
            r_words  <= '0;
            r_count  <= 6'd0;
            r_mode   <= 2'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_words    <= '0;
                        r_words[0] <= bus.TDATA;
                        r_count    <= 6'd1;
                        r_mode     <= bus.TUSER[1:0];
                        r_state    <= w_go_done ? S_DONE : S_COLLECT;
                        r_tready   <= ~w_go_done;
                        r_valid    <= w_go_done;
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        if (!w_full)
                            r_words[w_idx] <= bus.TDATA;
                        r_count <= w_cnt_nx;
                        if (w_go_done) begin
                            r_state  <= S_DONE;
                            r_tready <= 1'b0;
                            r_valid  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (w_hs) begin
                        r_state  <= S_IDLE;
                        r_count  <= 6'd0;
                        r_tready <= 1'b1;
                        r_valid  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SHA_DIGEST_LEN_CHECK_EN
    function automatic logic [5:0] f_exp_len(input logic [1:0] m);
        case (m)
            2'd0:    f_exp_len = 6'd14;
            2'd1:    f_exp_len = 6'd16;
            2'd2:    f_exp_len = 6'd24;
            default: f_exp_len = 6'd32;
        endcase
    endfunction

    logic r_err;
    logic w_err_nx;

    always_comb begin
        if (r_state == S_IDLE)
            w_err_nx = (f_exp_len(bus.TUSER[1:0]) != 6'd1);
        else
            w_err_nx = ~bus.TLAST | (w_cnt_nx != f_exp_len(r_mode));
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            r_err <= 1'b0;
        else if (w_go_done)
            r_err <= w_err_nx;
        else if (w_hs)
            r_err <= 1'b0;
    end

    assign bus.dig_err = r_err;
`else
    assign bus.dig_err = 1'b0;
`endif

    assign bus.TREADY    = r_tready;
    assign bus.dig_valid = r_valid;
    assign bus.digest    = r_words;
    assign bus.dig_words = r_count;
    assign bus.dig_mode  = r_mode;
endmodule
